sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO; generalised successor of the 8-bit fifo block.
//  Adds width/depth parameters, occupancy count, programmable almost-full/empty
//  thresholds, overflow/underflow error pulses and optional first-word-fall-through.
//  Sits between producer/consumer stages in one clock domain; drop-in for the old fifo.
// PARAMETERS
//  DATA_W    8        data width in bits
//  DEPTH     16       number of entries; power of 2, >= 4
//  AF_LEVEL  DEPTH-2  almost_full asserted when count >= AF_LEVEL
//  AE_LEVEL  2        almost_empty asserted when count <= AE_LEVEL
//  FWFT      0        0 = standard read (1-cycle latency), 1 = first-word-fall-through
// PORTS
//  clk           in   1                rising-edge clock
//  rst           in   1                synchronous reset, active-high
//  we            in   1                write request
//  re            in   1                read request
//  data_in       in   DATA_W           write data
//  data_out      out  DATA_W           read data
//  empty         out  1                count == 0
//  full          out  1                count == DEPTH
//  almost_empty  out  1                count <= AE_LEVEL
//  almost_full   out  1                count >= AF_LEVEL
//  count         out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//  overflow      out  1                1-cycle pulse: write rejected (full)
//  underflow     out  1                1-cycle pulse: read rejected (empty)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0, empty=1, full=0,
//    almost_empty=1, almost_full=0, data_out=0, overflow=underflow=0. Memory not
//    cleared. we/re ignored while rst=1; reset mid-operation discards all contents.
//  - Write accepted iff we && (!full || re_accepted); stores data_in at wr_ptr, wr_ptr++.
//  - Read accepted iff re && !empty. Pointers are log2(DEPTH) bits, wrap naturally.
//  - FWFT=0: on accepted read, data_out <= mem[rd_ptr] at that edge (valid the cycle
//    after re); data_out holds its last value otherwise, including on rejected read.
//  - FWFT=1: data_out = mem[rd_ptr] whenever !empty (valid the cycle after first write
//    into empty FIFO); accepted re pops, next word visible the following cycle.
//    data_out is don't-care while empty.
//  - count: +1 write only, -1 read only, unchanged if both or neither accepted.
//  - All status flags are registered and derived from the next count value, so they are
//    exact in the cycle after the causing edge.
//  - Simultaneous we&re when full: both accepted, count stays DEPTH, no overflow.
//  - Simultaneous we&re when empty: read rejected (underflow=1), write accepted, count=1.
//  - overflow=1 for one cycle after an edge with we && full && !re; write dropped.
//  - underflow=1 for one cycle after an edge with re && empty; pointers unchanged.
//  - Requires AE_LEVEL < AF_LEVEL <= DEPTH; violation is a configuration error.
// TESTING (DATA_W=8, DEPTH=16, defaults)
//  1 Reset: assert rst 1 cycle -> empty=1, full=0, count=0, almost_empty=1, data_out=0.
//  2 Fill: write 0x00..0x0F -> almost_full at count=14, full at 16; 17th write (0xFF)
//    -> overflow pulse 1 cycle, count=16, contents unchanged.
//  3 Drain: 16 reads -> data_out 0x00..0x0F in order, 1 cycle after each re; empty after
//    16th; 17th read -> underflow pulse, data_out holds 0x0F.
//  4 Simultaneous: we&re while full -> count=16, no overflow, order kept; we&re while
//    empty -> count=1, underflow pulse, written word read back next.
//  5 Wrap: write 10/read 10, then write 12 (0x20..0x2B)/read 12 -> exact order across
//    pointer wrap, count returns to 0.
//  6 FWFT=1: write 0xA5 into empty -> data_out=0xA5 next cycle with re=0; mid-fill (8
//    entries) assert rst -> count=0, empty=1; post-reset reads give underflow.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// Single-clock FIFO with configurable width and depth, an occupancy count,
// programmable almost-full/almost-empty thresholds, one-cycle overflow and
// underflow pulses, and an optional first-word-fall-through read port.
// All status outputs are registered and computed from the next occupancy,
// so every flag is exact in the cycle after the edge that caused it.

module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic                       re,
    input  logic [DATA_W-1:0]          data_in,
    output logic [DATA_W-1:0]          data_out,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

    // Thresholds must be ordered AE < AF <= DEPTH and DEPTH a power of two >= 4,
    // otherwise the flags would contradict each other or the pointers would not wrap.
    if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH && DEPTH >= 4 && (1 << PTR_W) == DEPTH)) begin : g_badConfig
        $error("sync_fifo_param: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic              r_empty;
    logic              r_full;
    logic              r_almostEmpty;
    logic              r_almostFull;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_rdAccept;
    logic              w_wrAccept;
    logic [CNT_W-1:0]  w_countNext;

    // A read needs data present; a write into a full FIFO is only allowed when a
    // read frees a slot at the same edge. Nothing is accepted while in reset.
    assign w_rdAccept = !rst && re && !r_empty;
    assign w_wrAccept = !rst && we && (!r_full || w_rdAccept);

    // Next occupancy: a simultaneous read and write leave the count unchanged.
    always_comb begin
        w_countNext = r_count;
        if (w_wrAccept && !w_rdAccept) begin
            w_countNext = r_count + CNT_W'(1);
        end else if (!w_wrAccept && w_rdAccept) begin
            w_countNext = r_count - CNT_W'(1);
        end
    end

    // Storage array; deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_wrAccept) begin
            r_mem[r_wrPtr] <= data_in;
        end
    end

    // Pointers, occupancy, registered status flags and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_count       <= '0;
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_almostEmpty <= 1'b1;
            r_almostFull  <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            if (w_wrAccept) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_rdAccept) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            r_count       <= w_countNext;
            r_empty       <= (w_countNext == '0);
            r_full        <= (w_countNext == DEPTH_CNT);
            r_almostEmpty <= (w_countNext <= AE_CNT);
            r_almostFull  <= (w_countNext >= AF_CNT);
            r_overflow    <= we && r_full && !re;
            r_underflow   <= re && r_empty;
        end
    end

    if (FWFT == 0) begin : g_stdRead
        logic [DATA_W-1:0] r_dataOut;

        // Standard read port: the word appears the cycle after an accepted read and
        // holds through idle cycles and rejected reads.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_dataOut <= '0;
            end else if (w_rdAccept) begin
                r_dataOut <= r_mem[r_rdPtr];
            end
        end

        assign data_out = r_dataOut;
    end else begin : g_fwftRead
        // Fall-through port: the head word is always visible; forced to zero while
        // empty so the output is deterministic after reset.
        assign data_out = r_empty ? '0 : r_mem[r_rdPtr];
    end

    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_empty = r_almostEmpty;
    assign almost_full  = r_almostFull;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param
// Table-driven bench for the standard-read FIFO plus a hand-written sequence for
// the first-word-fall-through variant. Expected values are computed by hand.

module tb_sync_fifo_param;

    typedef struct {
        logic       rst;
        logic       we;
        logic       re;
        logic [7:0] din;
        logic       chkDout;
        logic [7:0] dout;
        logic [4:0] cnt;
        logic       ovf;
        logic       udf;
    } vec_t;

    logic       clk;
    logic       rst0, we0, re0;
    logic [7:0] din0, dout0;
    logic       empty0, full0, ae0, af0, ovf0, udf0;
    logic [4:0] cnt0;

    logic       rst1, we1, re1;
    logic [7:0] din1, dout1;
    logic       empty1, full1, ae1, af1, ovf1, udf1;
    logic [4:0] cnt1;

    int checks;
    int errors;
    vec_t vecs[$];

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(0)) dutStd (
        .clk(clk), .rst(rst0), .we(we0), .re(re0), .data_in(din0),
        .data_out(dout0), .empty(empty0), .full(full0),
        .almost_empty(ae0), .almost_full(af0), .count(cnt0),
        .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(1)) dutFwft (
        .clk(clk), .rst(rst1), .we(we1), .re(re1), .data_in(din1),
        .data_out(dout1), .empty(empty1), .full(full1),
        .almost_empty(ae1), .almost_full(af1), .count(cnt1),
        .overflow(ovf1), .underflow(udf1)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void addVec(input logic r, input logic w, input logic rd,
                                   input logic [7:0] d, input logic cd,
                                   input logic [7:0] q, input logic [4:0] c,
                                   input logic o, input logic u);
        vec_t v;
        v.rst = r; v.we = w; v.re = rd; v.din = d; v.chkDout = cd;
        v.dout = q; v.cnt = c; v.ovf = o; v.udf = u;
        vecs.push_back(v);
    endfunction

    task automatic compare(input string name, input int idx,
                           input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Drives one vector onto the standard instance at the falling edge.
    task automatic applyStimulus(input vec_t v);
        rst0 = v.rst; we0 = v.we; re0 = v.re; din0 = v.din;
    endtask

    // Compares every output of the standard instance against one vector.
    task automatic checkOutput(input vec_t v, input int idx);
        compare("count", idx, 32'(cnt0), 32'(v.cnt));
        compare("empty", idx, 32'(empty0), 32'(v.cnt == 5'd0));
        compare("full", idx, 32'(full0), 32'(v.cnt == 5'd16));
        compare("almost_empty", idx, 32'(ae0), 32'(v.cnt <= 5'd2));
        compare("almost_full", idx, 32'(af0), 32'(v.cnt >= 5'd14));
        compare("overflow", idx, 32'(ovf0), 32'(v.ovf));
        compare("underflow", idx, 32'(udf0), 32'(v.udf));
        if (v.chkDout) compare("data_out", idx, 32'(dout0), 32'(v.dout));
    endtask

    // One clock of the fall-through instance, checked #1 after the rising edge.
    task automatic fwftStep(input string name, input logic r, input logic w, input logic rd,
                            input logic [7:0] d, input logic cd, input logic [7:0] q,
                            input logic [4:0] c, input logic u);
        rst1 = r; we1 = w; re1 = rd; din1 = d;
        @(posedge clk);
        #1;
        compare({name, " count"}, 0, 32'(cnt1), 32'(c));
        compare({name, " empty"}, 0, 32'(empty1), 32'(c == 5'd0));
        compare({name, " underflow"}, 0, 32'(udf1), 32'(u));
        if (cd) compare({name, " data_out"}, 0, 32'(dout1), 32'(q));
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst0 = 1'b1; we0 = 1'b0; re0 = 1'b0; din0 = '0;
        rst1 = 1'b1; we1 = 1'b0; re1 = 1'b0; din1 = '0;

        // Reset, with write and read requests that must be ignored.
        addVec(1, 1, 1, 8'h99, 1, 8'h00, 5'd0, 0, 0);
        // Fill 0x00..0x0F; data_out holds its reset value.
        for (int i = 0; i < 16; i++) addVec(0, 1, 0, 8'(i), 1, 8'h00, 5'(i + 1), 0, 0);
        // Write into full: overflow pulse, then it clears.
        addVec(0, 1, 0, 8'hFF, 1, 8'h00, 5'd16, 1, 0);
        addVec(0, 0, 0, 8'h00, 1, 8'h00, 5'd16, 0, 0);
        // Drain in order; 0xFF must never appear.
        for (int i = 0; i < 16; i++) addVec(0, 0, 1, 8'h00, 1, 8'(i), 5'(15 - i), 0, 0);
        // Read from empty: underflow pulse, data_out holds 0x0F.
        addVec(0, 0, 1, 8'h00, 1, 8'h0F, 5'd0, 0, 1);
        addVec(0, 0, 0, 8'h00, 1, 8'h0F, 5'd0, 0, 0);
        // Refill with 0x40..0x4F, then write+read while full.
        for (int i = 0; i < 16; i++) addVec(0, 1, 0, 8'(8'h40 + i), 1, 8'h0F, 5'(i + 1), 0, 0);
        addVec(0, 1, 1, 8'h50, 1, 8'h40, 5'd16, 0, 0);
        for (int i = 0; i < 16; i++) addVec(0, 0, 1, 8'h00, 1, 8'(8'h41 + i), 5'(15 - i), 0, 0);
        // Write+read while empty: read rejected, write lands, then read it back.
        addVec(0, 1, 1, 8'h77, 1, 8'h50, 5'd1, 0, 1);
        addVec(0, 0, 1, 8'h00, 1, 8'h77, 5'd0, 0, 0);
        // Wrap: 10 in / 10 out, then 12 in / 12 out.
        for (int i = 0; i < 10; i++) addVec(0, 1, 0, 8'(8'h10 + i), 1, 8'h77, 5'(i + 1), 0, 0);
        for (int i = 0; i < 10; i++) addVec(0, 0, 1, 8'h00, 1, 8'(8'h10 + i), 5'(9 - i), 0, 0);
        for (int i = 0; i < 12; i++) addVec(0, 1, 0, 8'(8'h20 + i), 1, 8'h19, 5'(i + 1), 0, 0);
        for (int i = 0; i < 12; i++) addVec(0, 0, 1, 8'h00, 1, 8'(8'h20 + i), 5'(11 - i), 0, 0);

        @(negedge clk);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput(vecs[i], i);
            @(negedge clk);
        end
        rst0 = 1'b0; we0 = 1'b0; re0 = 1'b0;

        // Fall-through instance.
        fwftStep("fwft reset", 1, 0, 0, 8'h00, 1, 8'h00, 5'd0, 0);
        fwftStep("fwft first word", 0, 1, 0, 8'hA5, 1, 8'hA5, 5'd1, 0);
        fwftStep("fwft hold", 0, 0, 0, 8'h00, 1, 8'hA5, 5'd1, 0);
        fwftStep("fwft second write", 0, 1, 0, 8'hB6, 1, 8'hA5, 5'd2, 0);
        fwftStep("fwft pop", 0, 0, 1, 8'h00, 1, 8'hB6, 5'd1, 0);
        for (int i = 0; i < 7; i++)
            fwftStep("fwft fill", 0, 1, 0, 8'(8'hC0 + i), 1, 8'hB6, 5'(i + 2), 0);
        fwftStep("fwft mid reset", 1, 1, 1, 8'hEE, 0, 8'h00, 5'd0, 0);
        fwftStep("fwft read after reset", 0, 0, 1, 8'h00, 0, 8'h00, 5'd0, 1);
        fwftStep("fwft idle", 0, 0, 0, 8'h00, 0, 8'h00, 5'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
